// File: rtl/uart_transmitter.sv
// uart_transmitter: 8E1 serial transmitter with a 16x oversampled baud divider
// for a 50 MHz clock. One byte per write strobe; frame = start, 8 data LSB first,
// even parity, stop.
module uart_transmitter (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] Tx_DATA,
    input  logic [2:0] baud_select,
    input  logic       Tx_WR,
    input  logic       Tx_EN,
    output logic       TxD,
    output logic       Tx_BUSY
);

    localparam int unsigned DIV_W  = 14;
    localparam int unsigned TICK_W = 4;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned DATA_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_e;

    // Terminal count (N-1) of the 16x divider for each rate select.
    function automatic logic [DIV_W-1:0] div_limit(input logic [2:0] sel);
        logic [DIV_W-1:0] lim;
        case (sel)
            3'd0:    lim = DIV_W'(10416);
            3'd1:    lim = DIV_W'(2603);
            3'd2:    lim = DIV_W'(650);
            3'd3:    lim = DIV_W'(325);
            3'd4:    lim = DIV_W'(162);
            3'd5:    lim = DIV_W'(80);
            3'd6:    lim = DIV_W'(53);
            default: lim = DIV_W'(26);
        endcase
        return lim;
    endfunction

    state_e              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [DIV_W-1:0]    limit_q, limit_d;
    logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
    logic [IDX_W-1:0]    bit_idx_q, bit_idx_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                txd_q, txd_d;
    logic                busy_q, busy_d;

    logic tick_c;
    logic bit_done_c;
    logic accept_c;

    assign tick_c     = (div_q == limit_q);
    assign bit_done_c = tick_c && (tick_cnt_q == TICK_W'(15));
    assign accept_c   = (state_q == ST_IDLE) && Tx_EN && Tx_WR;

    assign TxD     = txd_q;
    assign Tx_BUSY = busy_q;

    // Baud divider: restarts on accept, held at 0 while disabled; the rate
    // select is only picked up when the count returns to 0.
    always_comb begin
        div_d   = div_q + DIV_W'(1);
        limit_d = limit_q;
        if (!Tx_EN || accept_c || tick_c) begin
            div_d   = '0;
            limit_d = div_limit(baud_select);
        end
    end

    // Frame sequencer and registered line/busy outputs.
    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_idx_d  = bit_idx_q;
        data_d     = data_q;
        txd_d      = 1'b1;
        busy_d     = 1'b0;

        if (state_q != ST_IDLE && tick_c) begin
            tick_cnt_d = tick_cnt_q + TICK_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                tick_cnt_d = '0;
                if (accept_c) begin
                    data_d    = Tx_DATA;
                    bit_idx_d = '0;
                    state_d   = ST_START;
                end
            end
            ST_START: begin
                if (bit_done_c) begin
                    bit_idx_d = '0;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_done_c) begin
                    if (bit_idx_q == IDX_W'(7)) begin
                        state_d = ST_PARITY;
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (bit_done_c) begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_done_c) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Disable aborts any frame on the next edge.
        if (!Tx_EN) begin
            state_d    = ST_IDLE;
            tick_cnt_d = '0;
            bit_idx_d  = '0;
        end

        case (state_d)
            ST_START: begin
                txd_d  = 1'b0;
                busy_d = 1'b1;
            end
            ST_DATA: begin
                txd_d  = data_d[bit_idx_d];
                busy_d = 1'b1;
            end
            ST_PARITY: begin
                txd_d  = ^data_d;
                busy_d = 1'b1;
            end
            ST_STOP: begin
                txd_d  = 1'b1;
                busy_d = 1'b1;
            end
            default: begin
                txd_d  = 1'b1;
                busy_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            div_q      <= '0;
            limit_q    <= '0;
            tick_cnt_q <= '0;
            bit_idx_q  <= '0;
            data_q     <= '0;
            txd_q      <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            limit_q    <= limit_d;
            tick_cnt_q <= tick_cnt_d;
            bit_idx_q  <= bit_idx_d;
            data_q     <= data_d;
            txd_q      <= txd_d;
            busy_q     <= busy_d;
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: frame shape, bit timing, strobe
// handling, enable abort and asynchronous reset.
module tb_uart_transmitter;

    logic       clk;
    logic       reset;
    logic [7:0] Tx_DATA;
    logic [2:0] baud_select;
    logic       Tx_WR;
    logic       Tx_EN;
    logic       TxD;
    logic       Tx_BUSY;

    int checks;
    int errors;

    uart_transmitter dut (
        .clk         (clk),
        .reset       (reset),
        .Tx_DATA     (Tx_DATA),
        .baud_select (baud_select),
        .Tx_WR       (Tx_WR),
        .Tx_EN       (Tx_EN),
        .TxD         (TxD),
        .Tx_BUSY     (Tx_BUSY)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Starts at a negedge: strobes d for one cycle, then checks every bit at
    // its first and last cycle; ends at the first idle negedge.
    task automatic run_frame(input string name, input logic [7:0] d,
                             input logic [10:0] frame, input int bitclk);
        Tx_DATA = d;
        Tx_WR   = 1'b1;
        @(negedge clk);
        Tx_WR   = 1'b0;
        Tx_DATA = ~d;
        for (int b = 0; b < 11; b++) begin
            chk($sformatf("%s_bit%0d_first_txd", name, b), TxD, frame[b]);
            chk($sformatf("%s_bit%0d_first_busy", name, b), Tx_BUSY, 1'b1);
            repeat (bitclk - 1) @(negedge clk);
            chk($sformatf("%s_bit%0d_last_txd", name, b), TxD, frame[b]);
            chk($sformatf("%s_bit%0d_last_busy", name, b), Tx_BUSY, 1'b1);
            @(negedge clk);
        end
        chk($sformatf("%s_end_txd", name), TxD, 1'b1);
        chk($sformatf("%s_end_busy", name), Tx_BUSY, 1'b0);
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        reset       = 1'b0;
        Tx_DATA     = 8'h00;
        baud_select = 3'd7;
        Tx_WR       = 1'b0;
        Tx_EN       = 1'b0;

        // Reset held 25 cycles.
        repeat (25) @(negedge clk);
        chk("reset_txd", TxD, 1'b1);
        chk("reset_busy", Tx_BUSY, 1'b0);

        // Disabled: a strobe does nothing.
        reset   = 1'b1;
        Tx_DATA = 8'h99;
        Tx_WR   = 1'b1;
        @(negedge clk);
        Tx_WR = 1'b0;
        chk("dis_wr_txd", TxD, 1'b1);
        chk("dis_wr_busy", Tx_BUSY, 1'b0);
        repeat (50) @(negedge clk);
        chk("dis_later_txd", TxD, 1'b1);
        chk("dis_later_busy", Tx_BUSY, 1'b0);

        // 115200: 0x99, parity 0, 432 clocks per bit.
        Tx_EN = 1'b1;
        @(negedge clk);
        run_frame("f99", 8'h99, {1'b1, 1'b0, 8'h99, 1'b0}, 432);

        // Back-to-back: 0xAA (parity 0) then 0xAD (parity 1) on first idle cycle.
        repeat (10) @(negedge clk);
        run_frame("fAA", 8'hAA, {1'b1, 1'b0, 8'hAA, 1'b0}, 432);
        run_frame("fAD", 8'hAD, {1'b1, 1'b1, 8'hAD, 1'b0}, 432);

        // Abort during bit 4 (data bit 3) of 0x55, then a fresh 0x3C frame.
        repeat (5) @(negedge clk);
        Tx_DATA = 8'h55;
        Tx_WR   = 1'b1;
        @(negedge clk);
        Tx_WR = 1'b0;
        repeat (4 * 432 + 200) @(negedge clk);
        chk("abort_bit4_txd", TxD, 1'b0);
        chk("abort_bit4_busy", Tx_BUSY, 1'b1);
        Tx_EN = 1'b0;
        @(negedge clk);
        chk("abort_txd", TxD, 1'b1);
        chk("abort_busy", Tx_BUSY, 1'b0);
        Tx_WR = 1'b1;
        repeat (3) @(negedge clk);
        Tx_WR = 1'b0;
        chk("abort_wr_txd", TxD, 1'b1);
        chk("abort_wr_busy", Tx_BUSY, 1'b0);
        Tx_EN = 1'b1;
        @(negedge clk);
        run_frame("f3C", 8'h3C, {1'b1, 1'b0, 8'h3C, 1'b0}, 432);

        // 57600 (864 clocks per bit), strobe held 3 cycles, accepted once.
        baud_select = 3'd6;
        repeat (5) @(negedge clk);
        Tx_DATA = 8'h01;
        Tx_WR   = 1'b1;
        @(negedge clk);
        chk("b6_start_first", TxD, 1'b0);
        repeat (2) @(negedge clk);
        Tx_WR = 1'b0;
        repeat (861) @(negedge clk);
        chk("b6_start_last", TxD, 1'b0);
        chk("b6_start_last_busy", Tx_BUSY, 1'b1);
        @(negedge clk);
        chk("b6_d0_first", TxD, 1'b1);
        Tx_EN = 1'b0;
        @(negedge clk);
        chk("b6_abort_txd", TxD, 1'b1);
        chk("b6_abort_busy", Tx_BUSY, 1'b0);

        // 300: start bit is still running after 900 us; a write while busy is dropped.
        baud_select = 3'd0;
        Tx_EN       = 1'b1;
        repeat (3) @(negedge clk);
        Tx_DATA = 8'h99;
        Tx_WR   = 1'b1;
        @(negedge clk);
        Tx_WR = 1'b0;
        chk("b0_start_txd", TxD, 1'b0);
        chk("b0_start_busy", Tx_BUSY, 1'b1);
        repeat (44999) @(negedge clk);
        Tx_DATA = 8'hAA;
        Tx_WR   = 1'b1;
        @(negedge clk);
        Tx_WR = 1'b0;
        chk("b0_busy_wr_txd", TxD, 1'b0);
        chk("b0_busy_wr_busy", Tx_BUSY, 1'b1);
        repeat (2000) @(negedge clk);
        chk("b0_later_txd", TxD, 1'b0);
        chk("b0_later_busy", Tx_BUSY, 1'b1);
        Tx_EN = 1'b0;
        @(negedge clk);
        chk("b0_abort_txd", TxD, 1'b1);
        chk("b0_abort_busy", Tx_BUSY, 1'b0);

        // Asynchronous reset mid-frame at 115200.
        baud_select = 3'd7;
        Tx_EN       = 1'b1;
        @(negedge clk);
        Tx_DATA = 8'h00;
        Tx_WR   = 1'b1;
        @(negedge clk);
        Tx_WR = 1'b0;
        repeat (432 + 100) @(negedge clk);
        chk("rst_pre_txd", TxD, 1'b0);
        chk("rst_pre_busy", Tx_BUSY, 1'b1);
        #2 reset = 1'b0;
        #1;
        chk("rst_async_txd", TxD, 1'b1);
        chk("rst_async_busy", Tx_BUSY, 1'b0);

        // First edge after release with Tx_EN=1 accepts.
        @(negedge clk);
        Tx_DATA = 8'h0F;
        Tx_WR   = 1'b1;
        reset   = 1'b1;
        @(negedge clk);
        Tx_WR = 1'b0;
        chk("post_rst_txd", TxD, 1'b0);
        chk("post_rst_busy", Tx_BUSY, 1'b1);
        repeat (432) @(negedge clk);
        chk("post_rst_d0", TxD, 1'b1);
        Tx_EN = 1'b0;
        @(negedge clk);
        chk("post_rst_abort_busy", Tx_BUSY, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
